// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci engine.
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } fib_state_e;

    localparam int unsigned FIB_MAX_IDX_32 = 47;

endpackage

// File: rtl/fibonacci_iterative.sv
// Iterative Fibonacci engine with start/ready/done handshake and overflow flag.
// Optional build macro FIB_ABORT_EN adds an abort_i input that cancels a computation in OP.
module fibonacci_iterative
    import fib_pkg::*;
#(
    parameter int unsigned INDEX_W = 32,
    parameter int unsigned OUT_W   = 32,
    parameter int unsigned MAX_IDX = FIB_MAX_IDX_32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [INDEX_W-1:0] index_i,
`ifdef FIB_ABORT_EN
    input  logic               abort_i,
`endif
    output logic               ready_o,
    output logic               done_o,
    output logic               overflow_o,
    output logic [OUT_W-1:0]   fib_o
);

    fib_state_e         state, state_next;
    logic [INDEX_W-1:0] n_reg;
    logic [OUT_W-1:0]   t0, t1;
    logic               idx_too_big;
    logic               abort_req;

    assign idx_too_big = (index_i > INDEX_W'(MAX_IDX));

`ifdef FIB_ABORT_EN
    assign abort_req = abort_i;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = idx_too_big ? DONE : OP;
                end
            end
            OP: begin
                // Abort takes priority over completion in the same cycle.
                if (abort_req) begin
                    state_next = IDLE;
                end else if (n_reg == '0) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready_o = (state == IDLE);
        done_o  = (state == DONE);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fib_o      <= '0;
            overflow_o <= 1'b0;
            t0         <= '0;
            t1         <= '0;
            n_reg      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (idx_too_big) begin
                            fib_o      <= '1;
                            overflow_o <= 1'b1;
                        end else begin
                            n_reg      <= index_i;
                            t0         <= '0;
                            t1         <= OUT_W'(1);
                            overflow_o <= 1'b0;
                        end
                    end
                end
                OP: begin
                    if (!abort_req) begin
                        if (n_reg == '0) begin
                            fib_o <= t0;
                        end else begin
                            // t1 may wrap on the last step for MAX_IDX; only t0 is ever output.
                            t0    <= t1;
                            t1    <= t0 + t1;
                            n_reg <= n_reg - INDEX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fibonacci_iterative.sv
// Directed self-checking bench for fibonacci_iterative (abort tests when FIB_ABORT_EN is defined).
module tb_fibonacci_iterative;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] index_i = '0;
`ifdef FIB_ABORT_EN
    logic        abort_i = 1'b0;
`endif
    logic        ready_o;
    logic        done_o;
    logic        overflow_o;
    logic [31:0] fib_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    fibonacci_iterative #(
        .INDEX_W(32),
        .OUT_W  (32),
        .MAX_IDX(47)
    ) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .start_i   (start_i),
        .index_i   (index_i),
`ifdef FIB_ABORT_EN
        .abort_i   (abort_i),
`endif
        .ready_o   (ready_o),
        .done_o    (done_o),
        .overflow_o(overflow_o),
        .fib_o     (fib_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request on the negedge; returns #1 after the accepting edge.
    task automatic accept(input logic [31:0] idx, input string tag);
        @(negedge clk_i);
        chk({tag, "_ready_before"}, 64'(ready_o), 64'd1);
        start_i = 1'b1;
        index_i = idx;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        index_i = 32'hDEAD_BEEF;
    endtask

    // Counts edges after the current point until done_o is seen (bounded).
    task automatic wait_done(output int edges, output bit seen);
        edges = 0;
        seen  = done_o;
        while (!seen && edges < 200) begin
            @(posedge clk_i);
            #1;
            edges++;
            seen = done_o;
        end
    endtask

    task automatic run_req(input logic [31:0] idx, input logic [31:0] exp_fib,
                           input logic exp_ovf, input int exp_edges, input string tag);
        int  edges;
        bit  seen;
        accept(idx, tag);
        wait_done(edges, seen);
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        chk({tag, "_latency"}, 64'(edges), 64'(exp_edges));
        chk({tag, "_fib"}, 64'(fib_o), 64'(exp_fib));
        chk({tag, "_ovf"}, 64'(overflow_o), 64'(exp_ovf));
        @(posedge clk_i);
        #1;
        chk({tag, "_done_pulse"}, 64'(done_o), 64'd0);
        chk({tag, "_ready_after"}, 64'(ready_o), 64'd1);
        chk({tag, "_fib_held"}, 64'(fib_o), 64'(exp_fib));
    endtask

    initial begin
        int  edges;
        bit  seen;
        bit  done_any;

        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_fib", 64'(fib_o), 64'd0);
        chk("rst_ovf", 64'(overflow_o), 64'd0);
        chk("rst_ready", 64'(ready_o), 64'd1);
        chk("rst_done", 64'(done_o), 64'd0);
        @(negedge clk_i);
        reset_i = 1'b0;

        // Valid index n: done visible after n+1 further edges (cycle k+n+2).
        run_req(32'd0,  32'd0,          1'b0, 1,  "n0");
        run_req(32'd1,  32'd1,          1'b0, 2,  "n1");
        run_req(32'd10, 32'd55,         1'b0, 11, "n10");
        run_req(32'd47, 32'hB11924E1,   1'b0, 48, "n47");

        // Overflow index: done in cycle k+1, i.e. visible right after the accept edge.
        run_req(32'd48,        32'hFFFFFFFF, 1'b1, 0, "n48");
        run_req(32'hFFFFFFFF,  32'hFFFFFFFF, 1'b1, 0, "nmax");
        run_req(32'h0000_0100, 32'hFFFFFFFF, 1'b1, 0, "n256");
        run_req(32'd5,  32'd5,          1'b0, 6,  "n5");

        // Start during OP must be ignored.
        accept(32'd20, "ign");
        chk("ign_ready_op", 64'(ready_o), 64'd0);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b1;
        index_i = 32'd3;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        wait_done(edges, seen);
        chk("ign_done_seen", 64'(seen), 64'd1);
        chk("ign_latency", 64'(edges + 4), 64'd21);
        chk("ign_fib", 64'(fib_o), 64'd6765);
        chk("ign_ovf", 64'(overflow_o), 64'd0);
        @(posedge clk_i);
        #1;
        chk("ign_ready_after", 64'(ready_o), 64'd1);

`ifdef FIB_ABORT_EN
        // Abort sampled at edge k+5: IDLE from cycle k+6, outputs unchanged.
        accept(32'd30, "abt");
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        abort_i = 1'b1;
        @(posedge clk_i);
        #1;
        abort_i = 1'b0;
        chk("abt_ready", 64'(ready_o), 64'd1);
        chk("abt_done", 64'(done_o), 64'd0);
        chk("abt_fib", 64'(fib_o), 64'd6765);
        chk("abt_ovf", 64'(overflow_o), 64'd0);
        done_any = 1'b0;
        repeat (30) begin
            @(posedge clk_i);
            #1;
            if (done_o) done_any = 1'b1;
        end
        chk("abt_no_done", 64'(done_any), 64'd0);
        run_req(32'd6, 32'd8, 1'b0, 7, "abt_n6");
`endif

        // Asynchronous reset in the middle of OP.
        accept(32'd20, "rmid");
        repeat (5) @(posedge clk_i);
        #2;
        reset_i = 1'b1;
        #1;
        chk("rmid_ready", 64'(ready_o), 64'd1);
        chk("rmid_done", 64'(done_o), 64'd0);
        chk("rmid_fib", 64'(fib_o), 64'd0);
        chk("rmid_ovf", 64'(overflow_o), 64'd0);
        @(negedge clk_i);
        reset_i = 1'b0;
        done_any = 1'b0;
        repeat (30) begin
            @(posedge clk_i);
            #1;
            if (done_o) done_any = 1'b1;
        end
        chk("rmid_no_done", 64'(done_any), 64'd0);
        chk("rmid_fib_idle", 64'(fib_o), 64'd0);
        run_req(32'd3, 32'd2, 1'b0, 4, "post_rst_n3");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fibonacci_iterative.md
Name: fibonacci_iterative

Overview:
Iterative Fibonacci engine sitting directly downstream of the BCD-to-binary converter in the Fibonacci datapath. It accepts a binary index n, computes fib(n) by repeated addition, and presents the result to the binary-to-BCD/display stage. It uses a start/ready/done handshake and flags indices whose result would not fit the output width.

Parameters:
INDEX_W, 32, width of index input; matches the 32-bit binary output of the upstream converter.
OUT_W, 32, width of result.
MAX_IDX, 47, largest index whose result fits OUT_W (fib(47)=2971215073 < 2^32).

Ports:
clk_i  in  1  clock.
reset_i  in  1  asynchronous, active-high reset.
start_i  in  1  request; sampled only while ready_o=1.
index_i  in  INDEX_W  Fibonacci index n; captured on accepted start.
ready_o  out  1  high only in IDLE (combinational from state).
done_o  out  1  single-cycle pulse in DONE.
overflow_o  out  1  registered; 1 if the last request had n > MAX_IDX.
fib_o  out  OUT_W  registered result; held until the next result load.

Behaviour:
- Reset clocking: reset_i is asynchronous, active-high; clock is clk_i. Reset forces state IDLE, fib_o=0, overflow_o=0, t0=0, t1=0, n_reg=0; done_o=0; ready_o=1.
- States: IDLE, OP, DONE.
- IDLE: ready_o=1. On start_i with index_i > MAX_IDX: go to DONE; load fib_o to all ones; set overflow_o=1. On start_i otherwise: go to OP; n_reg=index_i, t0=0, t1=1, overflow_o=0.
- OP: if n_reg==0, fib_o<=t0 and go to DONE. Otherwise t0<=t1, t1<=t0+t1 (OUT_W-bit add), n_reg<=n_reg-1.
- DONE: done_o=1 for exactly one cycle, then return to IDLE.
- Latency, start accepted at edge k: valid index gives done_o high in cycle k+n+2. Overflow index gives done_o high in cycle k+1. fib_o and overflow_o are valid in the done_o cycle and held afterwards.
- start_i in OP/DONE: ignored, with no queuing. index_i is don't-care outside an accepted start.
- The t1 add may wrap on the final iteration for n=MAX_IDX. This is harmless because only t0 is output. The comparison against MAX_IDX uses the full INDEX_W width.
- Reset mid-OP: immediate return to IDLE. The partial result is discarded and no done_o is issued.

Optional Feature:
Macro FIB_ABORT_EN.
- Defined: adds input abort_i (1 bit). When abort_i=1 in OP, go to IDLE next cycle. fib_o and overflow_o keep their previous values and no done_o is issued. abort_i is ignored in IDLE/DONE. If abort_i and n_reg==0 occur in the same cycle, the abort wins.
- Undefined: no abort_i port; OP always runs to completion.

Decomposition:
- Shared package fib_pkg: state enum type (IDLE, OP, DONE, 2-bit); constant FIB_MAX_IDX_32=47.
- Single module, no sub-module. The adder and down-counter are inline.

Test Plan:
- Reset, then start_i with index_i=0 at edge k -> done_o pulse in cycle k+2, fib_o=0, overflow_o=0.
- index_i=1 -> fib_o=1 at k+3. index_i=10 -> fib_o=55, done_o in cycle k+12.
- index_i=47 -> fib_o=2971215073 (0xB11924E1), overflow_o=0, done_o at k+49.
- index_i=48, then 0xFFFFFFFF -> done_o at k+1, fib_o=0xFFFFFFFF, overflow_o=1. A following index_i=5 clears overflow_o and gives fib_o=5.
- index_i=20; pulse start_i=1 with index_i=3 during OP -> ignored, fib_o=6765. Assert reset_i mid-OP -> IDLE, fib_o=0, no done_o.
- FIB_ABORT_EN: index_i=30, abort_i at cycle k+5 -> IDLE at k+6, no done_o, fib_o unchanged. A following index_i=6 gives fib_o=8.
